// File: rtl/qmem_bus_arbiter.sv
// Fixed-priority MN-master to single-slave QMEM arbiter.
// Routes requests and responses combinationally and holds the grant while a transfer is pending.
module qmem_bus_arbiter #(
    parameter int QAW = 32,
    parameter int QDW = 32,
    parameter int QSW = QDW / 8,
    parameter int MN  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MN-1:0]           qm_cs,
    input  logic [MN-1:0]           qm_we,
    input  logic [MN-1:0][QSW-1:0]  qm_sel,
    input  logic [MN-1:0][QAW-1:0]  qm_adr,
    input  logic [MN-1:0][QDW-1:0]  qm_dat_w,
    output logic [MN-1:0][QDW-1:0]  qm_dat_r,
    output logic [MN-1:0]           qm_ack,
    output logic [MN-1:0]           qm_err,
    output logic                    qs_cs,
    output logic                    qs_we,
    output logic [QSW-1:0]          qs_sel,
    output logic [QAW-1:0]          qs_adr,
    output logic [QDW-1:0]          qs_dat_w,
    input  logic [QDW-1:0]          qs_dat_r,
    input  logic                    qs_ack,
    input  logic                    qs_err,
    output logic [MN-1:0]           ms
);

    logic [MN-1:0] owner_r;
    logic [MN-1:0] grant_s;
    logic          resp_ok_s;

    // One-hot of the lowest-index set bit; zero when nothing is requested.
    function automatic logic [MN-1:0] first_one(input logic [MN-1:0] req);
        logic [MN-1:0] onehot;
        onehot = '0;
        for (int i = MN - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
            end else begin
                onehot = onehot;
            end
        end
        return onehot;
    endfunction

    // Locked owner wins outright; otherwise fixed priority over live requests.
    always_comb begin
        if (owner_r != '0) begin
            grant_s = owner_r;
        end else begin
            grant_s = first_one(qm_cs);
        end
    end

    // Request mux: grant is one-hot or zero, so an AND-OR select idles at zero.
    always_comb begin
        qs_cs    = 1'b0;
        qs_we    = 1'b0;
        qs_sel   = '0;
        qs_adr   = '0;
        qs_dat_w = '0;
        for (int i = 0; i < MN; i++) begin
            qs_cs    = qs_cs | (grant_s[i] & qm_cs[i]);
            qs_we    = qs_we | (grant_s[i] & qm_we[i]);
            qs_sel   = qs_sel   | ({QSW{grant_s[i]}} & qm_sel[i]);
            qs_adr   = qs_adr   | ({QAW{grant_s[i]}} & qm_adr[i]);
            qs_dat_w = qs_dat_w | ({QDW{grant_s[i]}} & qm_dat_w[i]);
        end
    end

    // Responses count only while a request is actually presented to the slave.
    assign resp_ok_s = qs_cs;
    assign qm_ack    = {MN{qs_ack & resp_ok_s}} & grant_s;
    assign qm_err    = {MN{qs_err & resp_ok_s}} & grant_s;
    assign ms        = grant_s;

    // Read data is broadcast; only the acknowledged master samples it.
    always_comb begin
        for (int i = 0; i < MN; i++) begin
            qm_dat_r[i] = qs_dat_r;
        end
    end

    // Lock the grant across a pending transfer; release on ack, err, abort or idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_r <= '0;
        end else if (qs_cs && !qs_ack && !qs_err) begin
            owner_r <= grant_s;
        end else begin
            owner_r <= '0;
        end
    end

endmodule

// File: tb/tb_qmem_bus_arbiter.sv
// Self-checking bench for qmem_bus_arbiter: directed scenarios plus randomized
// traffic checked against an index-based reference model.
module tb_qmem_bus_arbiter;

    localparam int QAW = 32;
    localparam int QDW = 32;
    localparam int QSW = 4;
    localparam int MN  = 2;

    logic                    clk;
    logic                    rst;
    logic [MN-1:0]           qm_cs;
    logic [MN-1:0]           qm_we;
    logic [MN-1:0][QSW-1:0]  qm_sel;
    logic [MN-1:0][QAW-1:0]  qm_adr;
    logic [MN-1:0][QDW-1:0]  qm_dat_w;
    logic [MN-1:0][QDW-1:0]  qm_dat_r;
    logic [MN-1:0]           qm_ack;
    logic [MN-1:0]           qm_err;
    logic                    qs_cs;
    logic                    qs_we;
    logic [QSW-1:0]          qs_sel;
    logic [QAW-1:0]          qs_adr;
    logic [QDW-1:0]          qs_dat_w;
    logic [QDW-1:0]          qs_dat_r;
    logic                    qs_ack;
    logic                    qs_err;
    logic [MN-1:0]           ms;

    int checks;
    int passed;

    qmem_bus_arbiter #(.QAW(QAW), .QDW(QDW), .QSW(QSW), .MN(MN)) dut (
        .clk(clk), .rst(rst),
        .qm_cs(qm_cs), .qm_we(qm_we), .qm_sel(qm_sel), .qm_adr(qm_adr),
        .qm_dat_w(qm_dat_w), .qm_dat_r(qm_dat_r), .qm_ack(qm_ack), .qm_err(qm_err),
        .qs_cs(qs_cs), .qs_we(qs_we), .qs_sel(qs_sel), .qs_adr(qs_adr),
        .qs_dat_w(qs_dat_w), .qs_dat_r(qs_dat_r), .qs_ack(qs_ack), .qs_err(qs_err),
        .ms(ms)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        qm_cs = '0; qm_we = '0; qm_sel = '0; qm_adr = '0; qm_dat_w = '0;
        qs_dat_r = '0; qs_ack = 1'b0; qs_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        #12;
        checks++;
        if ({ms, qs_cs, qm_ack} !== 5'b0) $display("FAIL reset_idle got=%b exp=%b", {ms, qs_cs, qm_ack}, 5'b0);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #2;
            checks++;
            if ({ms, qs_cs, qm_ack} !== 5'b0) $display("FAIL idle_cycle%0d got=%b exp=%b", c, {ms, qs_cs, qm_ack}, 5'b0);
            else passed++;
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        qm_cs = 2'b10; qm_we = 2'b00; qm_sel[1] = 4'hF; qm_adr[1] = 32'h10;
        #2;
        checks++;
        if ({ms, qs_adr, qm_ack} !== {2'b10, 32'h10, 2'b00}) $display("FAIL single_req got=%h exp=%h", {ms, qs_adr, qm_ack}, {2'b10, 32'h10, 2'b00});
        else passed++;
        @(negedge clk);
        qs_ack = 1'b1; qs_dat_r = 32'hDEADBEEF;
        #2;
        checks++;
        if ({ms, qs_adr, qm_ack, qm_dat_r[1]} !== {2'b10, 32'h10, 2'b10, 32'hDEADBEEF})
            $display("FAIL single_ack got=%h exp=%h", {ms, qs_adr, qm_ack, qm_dat_r[1]}, {2'b10, 32'h10, 2'b10, 32'hDEADBEEF});
        else passed++;
        @(negedge clk);
        qm_cs = 2'b00; qs_ack = 1'b0;
        #2;
        checks++;
        if (ms !== 2'b00) $display("FAIL single_release got=%b exp=%b", ms, 2'b00);
        else passed++;
    endtask

    task automatic test_collision();
        @(negedge clk);
        qm_cs = 2'b11; qm_we = 2'b01;
        qm_sel[0] = 4'hF; qm_adr[0] = 32'h4; qm_dat_w[0] = 32'h12345678;
        qm_sel[1] = 4'hF; qm_adr[1] = 32'h8; qm_dat_w[1] = 32'h0;
        qs_ack = 1'b1;
        #2;
        checks++;
        if ({ms, qs_we, qs_sel, qs_adr, qs_dat_w, qm_ack} !== {2'b01, 1'b1, 4'hF, 32'h4, 32'h12345678, 2'b01})
            $display("FAIL collision_m0 got=%h exp=%h", {ms, qs_we, qs_sel, qs_adr, qs_dat_w, qm_ack},
                     {2'b01, 1'b1, 4'hF, 32'h4, 32'h12345678, 2'b01});
        else passed++;
        @(negedge clk);
        qm_cs = 2'b10; qm_we = 2'b00;
        #2;
        checks++;
        if ({ms, qs_we, qs_adr, qm_ack} !== {2'b10, 1'b0, 32'h8, 2'b10})
            $display("FAIL collision_m1 got=%h exp=%h", {ms, qs_we, qs_adr, qm_ack}, {2'b10, 1'b0, 32'h8, 2'b10});
        else passed++;
        @(negedge clk);
        qm_cs = 2'b00; qs_ack = 1'b0;
        #2;
        checks++;
        if ({ms, qm_ack} !== 4'b0) $display("FAIL collision_idle got=%b exp=%b", {ms, qm_ack}, 4'b0);
        else passed++;
    endtask

    task automatic test_lock();
        logic [MN-1:0] exp_ms [6];
        logic [MN-1:0] exp_ack [6];
        logic [MN-1:0] cs_seq [6];
        logic          ack_seq [6];
        cs_seq  = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00};
        ack_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_ms  = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00};
        exp_ack = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            qm_cs = cs_seq[c]; qs_ack = ack_seq[c];
            #2;
            checks++;
            if ({ms, qm_ack} !== {exp_ms[c], exp_ack[c]})
                $display("FAIL lock_cycle%0d got=%b exp=%b", c, {ms, qm_ack}, {exp_ms[c], exp_ack[c]});
            else passed++;
        end
    endtask

    task automatic test_abort_err();
        @(negedge clk);
        qm_cs = 2'b10; qs_ack = 1'b0;
        #2;
        checks++;
        if (ms !== 2'b10) $display("FAIL abort_grant got=%b exp=%b", ms, 2'b10);
        else passed++;
        @(negedge clk);
        qm_cs = 2'b00; qs_ack = 1'b1;
        #2;
        checks++;
        if ({ms, qs_cs, qm_ack} !== {2'b10, 1'b0, 2'b00}) $display("FAIL abort_drop got=%b exp=%b", {ms, qs_cs, qm_ack}, {2'b10, 1'b0, 2'b00});
        else passed++;
        @(negedge clk);
        qs_ack = 1'b0;
        #2;
        checks++;
        if (ms !== 2'b00) $display("FAIL abort_release got=%b exp=%b", ms, 2'b00);
        else passed++;
        @(negedge clk);
        qm_cs = 2'b11; qs_err = 1'b1;
        #2;
        checks++;
        if ({ms, qm_err, qm_ack} !== {2'b01, 2'b01, 2'b00}) $display("FAIL err_route got=%b exp=%b", {ms, qm_err, qm_ack}, {2'b01, 2'b01, 2'b00});
        else passed++;
        @(negedge clk);
        qm_cs = 2'b00; qs_err = 1'b0;
        #2;
        checks++;
        if ({ms, qm_err} !== 4'b0) $display("FAIL err_release got=%b exp=%b", {ms, qm_err}, 4'b0);
        else passed++;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        qm_cs = 2'b01;
        @(negedge clk);
        qm_cs = 2'b00;
        #1;
        checks++;
        if ({ms, qs_cs} !== {2'b01, 1'b0}) $display("FAIL arst_locked got=%b exp=%b", {ms, qs_cs}, {2'b01, 1'b0});
        else passed++;
        rst = 1'b0;
        #1;
        checks++;
        if (ms !== 2'b00) $display("FAIL arst_clear got=%b exp=%b", ms, 2'b00);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_random();
        int owner;
        int g;
        logic [MN-1:0] exp_ms, exp_ack, exp_err;
        logic exp_cs, exp_we;
        logic [QSW-1:0] exp_sel;
        logic [QAW-1:0] exp_adr;
        logic [QDW-1:0] exp_dw;
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        owner = -1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < MN; i++) begin
                qm_cs[i]    = ($urandom_range(0, 2) != 0);
                qm_we[i]    = 1'($urandom_range(0, 1));
                qm_sel[i]   = 4'($urandom());
                qm_adr[i]   = $urandom();
                qm_dat_w[i] = $urandom();
            end
            qs_dat_r = $urandom();
            qs_ack   = ($urandom_range(0, 2) == 0);
            qs_err   = ($urandom_range(0, 9) == 0);
            g = owner;
            for (int i = 0; i < MN; i++) if (g < 0 && qm_cs[i]) g = i;
            exp_ms  = (g >= 0) ? MN'(1 << g) : '0;
            exp_cs  = (g >= 0) ? qm_cs[g] : 1'b0;
            exp_we  = (g >= 0) ? qm_we[g] : 1'b0;
            exp_sel = (g >= 0) ? qm_sel[g] : '0;
            exp_adr = (g >= 0) ? qm_adr[g] : '0;
            exp_dw  = (g >= 0) ? qm_dat_w[g] : '0;
            exp_ack = (exp_cs && qs_ack) ? exp_ms : '0;
            exp_err = (exp_cs && qs_err) ? exp_ms : '0;
            #2;
            checks++;
            if ({ms, qs_cs, qs_we, qs_sel, qs_adr, qs_dat_w, qm_ack, qm_err} !==
                {exp_ms, exp_cs, exp_we, exp_sel, exp_adr, exp_dw, exp_ack, exp_err})
                $display("FAIL random_cycle%0d got=%h exp=%h", c,
                         {ms, qs_cs, qs_we, qs_sel, qs_adr, qs_dat_w, qm_ack, qm_err},
                         {exp_ms, exp_cs, exp_we, exp_sel, exp_adr, exp_dw, exp_ack, exp_err});
            else passed++;
            checks++;
            if (qm_dat_r !== {qs_dat_r, qs_dat_r}) $display("FAIL random_datr%0d got=%h exp=%h", c, qm_dat_r, {qs_dat_r, qs_dat_r});
            else passed++;
            owner = (exp_cs && !qs_ack && !qs_err) ? g : -1;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_single();
        test_collision();
        test_lock();
        test_abort_err();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
